// File: rtl/fiber_req_arbiter.sv
// rtl/fiber_req_arbiter.sv - per-PE request FIFOs, round-robin arbiter and tag-steered response routing for one fiberBank
module fiber_req_arbiter #(
   parameter int NUM_PE     = 4,
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 64,
   parameter int FIFO_DEPTH = 4,
   parameter int TAG_DEPTH  = 8
) (
   input  logic                         i_clk,
   input  logic                         i_nreset,
   input  logic [NUM_PE*4-1:0]          i_pe_request_type,
   input  logic [NUM_PE*ADDR_WIDTH-1:0] i_pe_addr,
   input  logic [NUM_PE*DATA_WIDTH-1:0] i_pe_data,
   input  logic [NUM_PE-1:0]            i_pe_type_valid,
   output logic [NUM_PE-1:0]            o_pe_type_ready,
   output logic [DATA_WIDTH-1:0]        o_pe_rdata,
   output logic [NUM_PE-1:0]            o_pe_rdata_valid,
   input  logic [NUM_PE-1:0]            i_pe_rdata_ready,
   output logic [3:0]                   o_request_type,
   output logic [ADDR_WIDTH-1:0]        o_addr,
   output logic [DATA_WIDTH-1:0]        o_data,
   output logic                         o_type_valid,
   input  logic                         i_type_ready,
   input  logic [DATA_WIDTH-1:0]        i_bank_data,
   input  logic                         i_bank_data_valid,
   output logic                         o_bank_data_ready,
   output logic                         o_err_drop,
   output logic                         o_err_orphan
);
   // FIFO_DEPTH and TAG_DEPTH are powers of two >= 2 so the pointers wrap naturally.
   localparam int PW    = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
   localparam int FAW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int TAW   = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
   localparam int REQ_W = 4 + ADDR_WIDTH + DATA_WIDTH;
   localparam logic [3:0] TYPE_READ    = 4'b0010;
   localparam logic [3:0] TYPE_CONSUME = 4'b1000;

   logic [REQ_W-1:0]  pe_req        [NUM_PE];
   logic [REQ_W-1:0]  fifo_mem      [NUM_PE][FIFO_DEPTH];
   logic [FAW-1:0]    fifo_rd       [NUM_PE];
   logic [FAW-1:0]    fifo_wr       [NUM_PE];
   logic [FAW:0]      fifo_cnt      [NUM_PE];
   logic [NUM_PE-1:0] fifo_push;
   logic [NUM_PE-1:0] fifo_pop;
   logic [NUM_PE-1:0] fifo_nonempty;
   logic [NUM_PE-1:0] drop_req;

   logic [PW-1:0]     rr_ptr;
   logic [PW-1:0]     winner;
   logic [PW:0]       arb_idx;
   logic              found;
   logic              grant;
   logic [REQ_W-1:0]  gnt_req;
   logic [3:0]        gnt_type;

   logic [PW-1:0]     tag_mem [TAG_DEPTH];
   logic [TAW-1:0]    tag_rd;
   logic [TAW-1:0]    tag_wr;
   logic [TAW:0]      tag_cnt;
   logic              tag_full;
   logic              tag_empty;
   logic              tag_push;
   logic              tag_pop;
   logic [PW-1:0]     tag_head;

   // Intake: unpack PE channels, FIFO flags, and split accepted requests into stored vs dropped
   always_comb begin
      for (int p = 0; p < NUM_PE; p++) begin
         pe_req[p]          = {i_pe_request_type[p*4 +: 4],
                               i_pe_addr[p*ADDR_WIDTH +: ADDR_WIDTH],
                               i_pe_data[p*DATA_WIDTH +: DATA_WIDTH]};
         o_pe_type_ready[p] = (fifo_cnt[p] != (FAW+1)'(FIFO_DEPTH));
         fifo_nonempty[p]   = (fifo_cnt[p] != '0);
         fifo_push[p]       = i_pe_type_valid[p] && o_pe_type_ready[p] &&
                              $onehot(i_pe_request_type[p*4 +: 4]);
         drop_req[p]        = i_pe_type_valid[p] && o_pe_type_ready[p] &&
                              !$onehot(i_pe_request_type[p*4 +: 4]);
      end
   end

   // Round-robin search: first non-empty FIFO at or after the pointer, modulo NUM_PE
   always_comb begin
      found   = 1'b0;
      winner  = '0;
      arb_idx = '0;
      for (int k = 0; k < NUM_PE; k++) begin
         arb_idx = {1'b0, rr_ptr} + (PW+1)'(k);
         if (arb_idx >= (PW+1)'(NUM_PE)) begin
            arb_idx = arb_idx - (PW+1)'(NUM_PE);
         end
         if (!found && fifo_nonempty[arb_idx[PW-1:0]]) begin
            found  = 1'b1;
            winner = arb_idx[PW-1:0];
         end
      end
   end

   // A grant needs a free output slot and room in the tag FIFO; a full tag FIFO stalls everything
   assign grant    = found && (!o_type_valid || i_type_ready) && !tag_full;
   assign gnt_req  = fifo_mem[winner][fifo_rd[winner]];
   assign gnt_type = gnt_req[REQ_W-1 -: 4];

   // Only the winning FIFO pops
   always_comb begin
      for (int p = 0; p < NUM_PE; p++) begin
         fifo_pop[p] = grant && (winner == PW'(p));
      end
   end

   assign tag_full  = (tag_cnt == (TAW+1)'(TAG_DEPTH));
   assign tag_empty = (tag_cnt == '0);
   assign tag_head  = tag_mem[tag_rd];
   assign tag_push  = grant && ((gnt_type == TYPE_READ) || (gnt_type == TYPE_CONSUME));
   assign tag_pop   = i_nreset && !tag_empty && i_bank_data_valid && i_pe_rdata_ready[tag_head];

   // Response steering: the tag head owns the bank response; with no tag the response is sunk
   always_comb begin
      o_pe_rdata       = i_bank_data;
      o_pe_rdata_valid = '0;
      if (i_nreset && !tag_empty) begin
         o_pe_rdata_valid[tag_head] = i_bank_data_valid;
      end
      o_bank_data_ready = !i_nreset || tag_empty || i_pe_rdata_ready[tag_head];
   end

   // Request FIFO pointers and occupancy
   always_ff @(posedge i_clk) begin
      if (!i_nreset) begin
         for (int p = 0; p < NUM_PE; p++) begin
            fifo_rd[p]  <= '0;
            fifo_wr[p]  <= '0;
            fifo_cnt[p] <= '0;
         end
      end else begin
         for (int p = 0; p < NUM_PE; p++) begin
            if (fifo_push[p]) fifo_wr[p] <= fifo_wr[p] + FAW'(1);
            if (fifo_pop[p])  fifo_rd[p] <= fifo_rd[p] + FAW'(1);
            if (fifo_push[p] && !fifo_pop[p]) begin
               fifo_cnt[p] <= fifo_cnt[p] + (FAW+1)'(1);
            end else if (!fifo_push[p] && fifo_pop[p]) begin
               fifo_cnt[p] <= fifo_cnt[p] - (FAW+1)'(1);
            end
         end
      end
   end

   // Request FIFO storage (contents are don't-care until written)
   always_ff @(posedge i_clk) begin
      for (int p = 0; p < NUM_PE; p++) begin
         if (fifo_push[p]) fifo_mem[p][fifo_wr[p]] <= pe_req[p];
      end
   end

   // Output stage and round-robin pointer: load on grant, hold under backpressure, drain otherwise
   always_ff @(posedge i_clk) begin
      if (!i_nreset) begin
         rr_ptr         <= '0;
         o_type_valid   <= 1'b0;
         o_request_type <= '0;
         o_addr         <= '0;
         o_data         <= '0;
      end else if (grant) begin
         o_type_valid                       <= 1'b1;
         {o_request_type, o_addr, o_data}   <= gnt_req;
         rr_ptr <= (winner == PW'(NUM_PE-1)) ? '0 : winner + PW'(1);
      end else if (i_type_ready) begin
         o_type_valid <= 1'b0;
      end
   end

   // Tag FIFO pointers and occupancy; push and pop in one cycle leave the count unchanged
   always_ff @(posedge i_clk) begin
      if (!i_nreset) begin
         tag_rd  <= '0;
         tag_wr  <= '0;
         tag_cnt <= '0;
      end else begin
         if (tag_push) tag_wr <= tag_wr + TAW'(1);
         if (tag_pop)  tag_rd <= tag_rd + TAW'(1);
         if (tag_push && !tag_pop) begin
            tag_cnt <= tag_cnt + (TAW+1)'(1);
         end else if (!tag_push && tag_pop) begin
            tag_cnt <= tag_cnt - (TAW+1)'(1);
         end
      end
   end

   // Tag FIFO storage: originating PE index of each response-expecting request
   always_ff @(posedge i_clk) begin
      if (tag_push) tag_mem[tag_wr] <= winner;
   end

   // Error pulses, one cycle after the offending event
   always_ff @(posedge i_clk) begin
      if (!i_nreset) begin
         o_err_drop   <= 1'b0;
         o_err_orphan <= 1'b0;
      end else begin
         o_err_drop   <= |drop_req;
         o_err_orphan <= i_bank_data_valid && tag_empty;
      end
   end

endmodule

// File: tb/tb_fiber_req_arbiter.sv
// tb/tb_fiber_req_arbiter.sv - randomized and directed bench for fiber_req_arbiter against a queue-based model
module tb_fiber_req_arbiter;
   localparam int NUM_PE = 4;
   localparam int DW     = 16;
   localparam int AW     = 64;
   localparam int FD     = 4;
   localparam int TD     = 8;

   typedef struct packed {
      logic [3:0]    t;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } req_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              nreset;
   logic [3:0]        pe_type [NUM_PE];
   logic [AW-1:0]     pe_addr [NUM_PE];
   logic [DW-1:0]     pe_data [NUM_PE];
   logic [NUM_PE-1:0] pe_valid;
   logic [NUM_PE-1:0] rdata_ready;
   logic              type_ready;
   logic              bank_valid;
   logic [DW-1:0]     bank_data;

   logic [NUM_PE*4-1:0]  type_bus;
   logic [NUM_PE*AW-1:0] addr_bus;
   logic [NUM_PE*DW-1:0] data_bus;

   logic [NUM_PE-1:0] o_pe_type_ready;
   logic [DW-1:0]     o_pe_rdata;
   logic [NUM_PE-1:0] o_pe_rdata_valid;
   logic [3:0]        o_request_type;
   logic [AW-1:0]     o_addr;
   logic [DW-1:0]     o_data;
   logic              o_type_valid;
   logic              o_bank_data_ready;
   logic              o_err_drop;
   logic              o_err_orphan;

   always_comb begin
      for (int p = 0; p < NUM_PE; p++) begin
         type_bus[p*4 +: 4]   = pe_type[p];
         addr_bus[p*AW +: AW] = pe_addr[p];
         data_bus[p*DW +: DW] = pe_data[p];
      end
   end

   fiber_req_arbiter #(
      .NUM_PE(NUM_PE), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD), .TAG_DEPTH(TD)
   ) dut (
      .i_clk             (clk),
      .i_nreset          (nreset),
      .i_pe_request_type (type_bus),
      .i_pe_addr         (addr_bus),
      .i_pe_data         (data_bus),
      .i_pe_type_valid   (pe_valid),
      .o_pe_type_ready   (o_pe_type_ready),
      .o_pe_rdata        (o_pe_rdata),
      .o_pe_rdata_valid  (o_pe_rdata_valid),
      .i_pe_rdata_ready  (rdata_ready),
      .o_request_type    (o_request_type),
      .o_addr            (o_addr),
      .o_data            (o_data),
      .o_type_valid      (o_type_valid),
      .i_type_ready      (type_ready),
      .i_bank_data       (bank_data),
      .i_bank_data_valid (bank_valid),
      .o_bank_data_ready (o_bank_data_ready),
      .o_err_drop        (o_err_drop),
      .o_err_orphan      (o_err_orphan)
   );

   // Behavioural model state
   req_t mq [NUM_PE][$];
   int   tq [$];
   int   m_ptr = 0;
   bit   m_ov  = 1'b0;
   req_t m_out = '0;
   bit   m_drop = 1'b0;
   bit   m_orph = 1'b0;

   int n_checks = 0;
   int n_errs   = 0;
   int cyc      = 0;

   logic [AW-1:0] issued [$];
   int            issued_cyc [$];
   int            first_valid_cyc;
   int            n_drop_seen;
   int            n_orph_seen;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic idle();
      for (int p = 0; p < NUM_PE; p++) begin
         pe_type[p] = 4'b0;
         pe_addr[p] = '0;
         pe_data[p] = '0;
      end
      pe_valid    = '0;
      rdata_ready = '1;
      type_ready  = 1'b1;
      bank_valid  = 1'b0;
      bank_data   = '0;
   endtask

   // Compare every DUT output against the model for the current inputs
   task automatic settle();
      logic [NUM_PE-1:0] exp_ready;
      logic [NUM_PE-1:0] exp_rv;
      logic              exp_bready;
      #1;
      for (int p = 0; p < NUM_PE; p++) exp_ready[p] = (mq[p].size() < FD);
      exp_rv     = '0;
      exp_bready = 1'b1;
      if (nreset && tq.size() > 0) begin
         exp_rv[tq[0]] = bank_valid;
         exp_bready    = rdata_ready[tq[0]];
      end
      check("type_valid", o_type_valid, m_ov);
      if (m_ov) begin
         check("req_type", o_request_type, m_out.t);
         check("addr", o_addr, m_out.a);
         check("data", o_data, m_out.d);
      end
      check("pe_ready", o_pe_type_ready, exp_ready);
      check("rdata_valid", o_pe_rdata_valid, exp_rv);
      if (exp_rv != 0) check("rdata", o_pe_rdata, bank_data);
      check("bank_ready", o_bank_data_ready, exp_bready);
      check("err_drop", o_err_drop, m_drop);
      check("err_orphan", o_err_orphan, m_orph);
   endtask

   // Advance the model by one clock from the spec rules
   task automatic model_step();
      int   sz [NUM_PE];
      bit   found;
      int   win;
      int   idx;
      bit   nd;
      bit   no;
      req_t g;
      req_t r;
      if (!nreset) begin
         for (int p = 0; p < NUM_PE; p++) mq[p].delete();
         tq.delete();
         m_ptr = 0; m_ov = 0; m_out = '0; m_drop = 0; m_orph = 0;
         return;
      end
      for (int p = 0; p < NUM_PE; p++) sz[p] = mq[p].size();
      found = 0; win = 0; g = '0;
      if ((!m_ov || type_ready) && tq.size() < TD) begin
         for (int k = 0; k < NUM_PE; k++) begin
            idx = (m_ptr + k) % NUM_PE;
            if (!found && sz[idx] > 0) begin
               found = 1; win = idx;
            end
         end
      end
      if (found) g = mq[win].pop_front();
      nd = 0;
      for (int p = 0; p < NUM_PE; p++) begin
         if (pe_valid[p] && sz[p] < FD) begin
            if ($countones(pe_type[p]) == 1) begin
               r.t = pe_type[p]; r.a = pe_addr[p]; r.d = pe_data[p];
               mq[p].push_back(r);
            end else begin
               nd = 1;
            end
         end
      end
      no = bank_valid && (tq.size() == 0);
      if (tq.size() > 0 && bank_valid && rdata_ready[tq[0]]) void'(tq.pop_front());
      if (found && (g.t == 4'b0010 || g.t == 4'b1000)) tq.push_back(win);
      if (found) begin
         m_out = g; m_ov = 1; m_ptr = (win + 1) % NUM_PE;
      end else if (type_ready) begin
         m_ov = 0;
      end
      m_drop = nd;
      m_orph = no;
   endtask

   task automatic tick();
      if (o_type_valid === 1'b1 && type_ready) begin
         issued.push_back(o_addr);
         issued_cyc.push_back(cyc);
      end
      if (o_type_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (o_err_drop === 1'b1) n_drop_seen++;
      if (o_err_orphan === 1'b1) n_orph_seen++;
      model_step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         settle();
         tick();
      end
   endtask

   initial begin
      int a_cyc;
      int n_acc;
      first_valid_cyc = 0;
      n_drop_seen = 0;
      n_orph_seen = 0;
      idle();
      nreset = 1'b0;

      // Reset for 3 cycles; outputs are unknown until the first reset edge
      @(negedge clk);
      tick();
      idle_cycles(2);
      nreset = 1'b1;
      settle();
      check("rst_ready", o_pe_type_ready, 4'b1111);
      check("rst_valid", o_type_valid, 1'b0);
      check("rst_bready", o_bank_data_ready, 1'b1);
      check("rst_errs", {o_err_drop, o_err_orphan}, 2'b00);
      tick();

      // Round-robin fairness: all PEs push two WRITEs
      issued.delete(); issued_cyc.delete();
      first_valid_cyc = -1;
      a_cyc = cyc;
      for (int c = 0; c < 2; c++) begin
         for (int p = 0; p < NUM_PE; p++) begin
            pe_valid[p] = 1'b1;
            pe_type[p]  = 4'b0100;
            pe_addr[p]  = 64'hFFFF_FFFF_FFFF_FFF0 | 64'(p);
            pe_data[p]  = 16'hFFFF;
         end
         settle();
         tick();
      end
      idle();
      idle_cycles(10);
      check("rr_latency", 64'(first_valid_cyc - a_cyc), 64'd2);
      check("rr_count", 64'(issued.size()), 64'd8);
      for (int i = 0; i < issued.size() && i < 8; i++)
         check("rr_order", issued[i], 64'hFFFF_FFFF_FFFF_FFF0 | 64'(i % 4));
      if (issued_cyc.size() == 8)
         check("rr_back2back", 64'(issued_cyc[7] - issued_cyc[0]), 64'd7);

      // Backpressure: PE2 FETCHes against a stalled bank
      issued.delete(); issued_cyc.delete();
      type_ready = 1'b0;
      n_acc = 0;
      for (int k = 0; k < 6; k++) begin
         pe_valid[2] = 1'b1;
         pe_type[2]  = 4'b0001;
         pe_addr[2]  = 64'h200 + 64'(k);
         settle();
         if (o_pe_type_ready[2]) n_acc++;
         tick();
      end
      pe_valid = '0;
      for (int k = 0; k < 3; k++) begin
         settle();
         check("bp_hold_valid", o_type_valid, 1'b1);
         check("bp_hold_addr", o_addr, 64'h200);
         check("bp_full", o_pe_type_ready[2], 1'b0);
         tick();
      end
      check("bp_accepted", 64'(n_acc), 64'd5);
      type_ready = 1'b1;
      idle_cycles(8);
      check("bp_drain_count", 64'(issued.size()), 64'd5);
      for (int i = 0; i < issued.size() && i < 5; i++)
         check("bp_drain_order", issued[i], 64'h200 + 64'(i));
      settle();
      check("bp_ready_back", o_pe_type_ready[2], 1'b1);
      tick();

      // Response routing: PE1 READ then PE3 CONSUME
      idle();
      pe_valid[1] = 1'b1; pe_type[1] = 4'b0010; pe_addr[1] = 64'h11;
      settle(); tick();
      idle();
      pe_valid[3] = 1'b1; pe_type[3] = 4'b1000; pe_addr[3] = 64'h33;
      settle(); tick();
      idle();
      idle_cycles(4);
      bank_valid = 1'b1; bank_data = 16'h1234;
      settle();
      check("resp1_valid", o_pe_rdata_valid, 4'b0010);
      check("resp1_data", o_pe_rdata, 16'h1234);
      tick();
      bank_data = 16'hABCD; rdata_ready = 4'b0111;
      for (int k = 0; k < 2; k++) begin
         settle();
         check("resp2_valid", o_pe_rdata_valid, 4'b1000);
         check("resp2_stall", o_bank_data_ready, 1'b0);
         tick();
      end
      rdata_ready = 4'b1111;
      settle();
      check("resp2_go", o_bank_data_ready, 1'b1);
      check("resp2_data", o_pe_rdata, 16'hABCD);
      tick();
      idle();
      idle_cycles(2);

      // Tag full: nine READs, no responses
      issued.delete(); issued_cyc.delete();
      for (int c = 0; c < 3; c++) begin
         for (int p = 0; p < NUM_PE; p++) begin
            pe_valid[p] = (c < 2) || (p == 0);
            pe_type[p]  = 4'b0010;
            pe_addr[p]  = 64'h300 + 64'(c * NUM_PE + p);
         end
         settle();
         tick();
      end
      idle();
      idle_cycles(14);
      check("tag_full_issued", 64'(issued.size()), 64'd8);
      settle();
      check("tag_full_idle", o_type_valid, 1'b0);
      tick();
      bank_valid = 1'b1; bank_data = 16'h5555;
      settle(); tick();
      bank_valid = 1'b0;
      idle_cycles(4);
      check("tag_freed_issued", 64'(issued.size()), 64'd9);
      bank_valid = 1'b1;
      idle_cycles(8);
      bank_valid = 1'b0;
      idle_cycles(2);

      // Errors: non-one-hot type, then an orphan response
      issued.delete(); issued_cyc.delete();
      n_drop_seen = 0;
      pe_valid[0] = 1'b1; pe_type[0] = 4'b0110; pe_addr[0] = 64'h400;
      settle(); tick();
      idle();
      idle_cycles(4);
      check("drop_pulses", 64'(n_drop_seen), 64'd1);
      check("drop_no_req", 64'(issued.size()), 64'd0);
      n_orph_seen = 0;
      bank_valid = 1'b1; bank_data = 16'h7777;
      settle();
      check("orphan_no_route", o_pe_rdata_valid, 4'b0000);
      tick();
      bank_valid = 1'b0;
      idle_cycles(3);
      check("orphan_pulses", 64'(n_orph_seen), 64'd1);

      // Randomized traffic including occasional mid-run resets
      for (int i = 0; i < 3000; i++) begin
         nreset = ($urandom_range(0, 199) != 0);
         for (int p = 0; p < NUM_PE; p++) begin
            pe_valid[p] = 1'($urandom_range(0, 1));
            pe_type[p]  = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
            pe_addr[p]  = {$urandom, $urandom};
            pe_data[p]  = 16'($urandom);
         end
         type_ready  = ($urandom_range(0, 3) != 0);
         bank_valid  = ($urandom_range(0, 2) == 0);
         bank_data   = 16'($urandom);
         rdata_ready = 4'($urandom);
         settle();
         tick();
      end
      nreset = 1'b1;
      idle();
      idle_cycles(20);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
